// File: rtl/pldata_capture_mux.sv
// ============================================================================
// pldata_capture_mux : multi-source PL capture path with lane swap, ring BRAM
// addressing, per-frame done pulse and sticky interrupt.   Rev 1.0
// ============================================================================
`default_nettype none

module pldata_capture_mux #(
  parameter int                NUM_SRC     = 4,
  parameter int                SEL_W       = 2,
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                LEN_W       = 16,
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*DATA_W-1:0] src_data_in,
  input  logic [NUM_SRC-1:0]        src_valid_in,
  input  logic [SEL_W-1:0]          src_sel_in,
  input  logic [1:0]                swap_mode_in,
  input  logic                      ring_mode_in,
  input  logic [LEN_W-1:0]          frame_len_in,
  input  logic                      start_in,
  input  logic                      stop_in,
  input  logic                      intr_clr_in,
  output logic                      ram_wr_o,
  output logic [ADDR_W-1:0]         ram_addr_o,
  output logic [DATA_W-1:0]         ram_din_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      intr_o,
  output logic [LEN_W-1:0]          word_cnt_o,
  output logic [LEN_W-1:0]          frame_cnt_o,
  output logic                      err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int NB    = DATA_W / 8;
  localparam int NL    = DATA_W / 16;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CAPTURE = 2'd1, ST_DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [1:0]        swap_q, swap_d;
  logic              ring_q, ring_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
  logic [LEN_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              ram_wr_q, ram_wr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              done_q, done_d;
  logic              intr_q, intr_d;
  logic              err_q, err_d;

  logic              w_sel_vld;
  logic [DATA_W-1:0] w_sel_dat;
  logic              w_start_ok;
  logic              w_intr_set;
  logic [LEN_W-1:0]  w_cnt_inc;

  function automatic logic [DATA_W-1:0] swap_lanes(input logic [DATA_W-1:0] d,
                                                   input logic [1:0]        m);
    logic [DATA_W-1:0] r;
    r = d;
    case (m)
      2'd1: for (int l = 0; l < NL; l++) begin
              r[16*l +: 8]   = d[16*l+8 +: 8];
              r[16*l+8 +: 8] = d[16*l +: 8];
            end
      2'd2: for (int b = 0; b < NB; b++) r[8*b +: 8] = d[8*(NB-1-b) +: 8];
      2'd3: for (int l = 0; l < NL; l++) r[16*l +: 16] = d[16*(NL-1-l) +: 16];
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_dat = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel_q == SEL_W'(k)) begin
        w_sel_vld = src_valid_in[k];
        w_sel_dat = src_data_in[k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_start_ok = (frame_len_in != '0) && (32'(src_sel_in) < NUM_SRC);
  assign w_cnt_inc  = word_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    swap_d      = swap_q;
    ring_d      = ring_q;
    len_d       = len_q;
    idx_d       = idx_q;
    word_cnt_d  = word_cnt_q;
    frame_cnt_d = frame_cnt_q;
    ram_wr_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    done_d      = 1'b0;
    err_d       = err_q;
    w_intr_set  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_in && !stop_in) begin
          if (w_start_ok) begin
            state_d     = ST_CAPTURE;
            sel_d       = src_sel_in;
            swap_d      = swap_mode_in;
            ring_d      = ring_mode_in;
            len_d       = frame_len_in;
            idx_d       = '0;
            word_cnt_d  = '0;
            frame_cnt_d = '0;
            err_d       = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_CAPTURE: begin
        if (w_sel_vld) begin
          ram_wr_d   = 1'b1;
          ram_addr_d = BASE_ADDR + (ADDR_W'(idx_q) << 2);
          ram_din_d  = swap_lanes(w_sel_dat, swap_q);
          idx_d      = idx_q + 1'b1;
          word_cnt_d = w_cnt_inc;
          if (w_cnt_inc == len_q) begin
            // Ring frames close on the last word itself; one-shot goes via DONE.
            if (ring_q) begin
              word_cnt_d  = '0;
              done_d      = 1'b1;
              w_intr_set  = 1'b1;
              frame_cnt_d = frame_cnt_q + 1'b1;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        if (stop_in) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d      = 1'b1;
        w_intr_set  = 1'b1;
        frame_cnt_d = frame_cnt_q + 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    intr_d = w_intr_set ? 1'b1 : (intr_clr_in ? 1'b0 : intr_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      swap_q      <= '0;
      ring_q      <= 1'b0;
      len_q       <= '0;
      idx_q       <= '0;
      word_cnt_q  <= '0;
      frame_cnt_q <= '0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      done_q      <= 1'b0;
      intr_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      swap_q      <= swap_d;
      ring_q      <= ring_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      word_cnt_q  <= word_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      ram_wr_q    <= ram_wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      done_q      <= done_d;
      intr_q      <= intr_d;
      err_q       <= err_d;
    end
  end

  assign ram_wr_o    = ram_wr_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_din_o   = ram_din_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign intr_o      = intr_q;
  assign word_cnt_o  = word_cnt_q;
  assign frame_cnt_o = frame_cnt_q;
  assign err_o       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pldata_capture_mux.sv
// ============================================================================
// tb_pldata_capture_mux : directed self-checking bench for pldata_capture_mux.
// ============================================================================
`default_nettype none

module tb_pldata_capture_mux;

  localparam int NS = 4;
  localparam int DW = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0]  src_valid;
  logic [2:0]     src_sel;
  logic [1:0]     swap_mode;
  logic           ring_mode;
  logic [15:0]    frame_len;
  logic           start, stop, intr_clr;
  logic           ram_wr, busy, done, intr, err;
  logic [31:0]    ram_addr;
  logic [31:0]    ram_din;
  logic [15:0]    word_cnt, frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pldata_capture_mux #(
    .NUM_SRC(NS), .SEL_W(3), .DATA_W(DW), .ADDR_W(32), .LEN_W(16),
    .DEPTH_WORDS(4), .BASE_ADDR(32'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .src_data_in(src_data), .src_valid_in(src_valid), .src_sel_in(src_sel),
    .swap_mode_in(swap_mode), .ring_mode_in(ring_mode), .frame_len_in(frame_len),
    .start_in(start), .stop_in(stop), .intr_clr_in(intr_clr),
    .ram_wr_o(ram_wr), .ram_addr_o(ram_addr), .ram_din_o(ram_din),
    .busy_o(busy), .done_o(done), .intr_o(intr),
    .word_cnt_o(word_cnt), .frame_cnt_o(frame_cnt), .err_o(err)
  );

  // Inputs change and outputs are checked 1 time unit after each rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [2:0] s, input logic [1:0] sw,
                             input logic r, input logic [15:0] l);
    src_sel = s; swap_mode = sw; ring_mode = r; frame_len = l;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(); cyc();
    n_tests++;
    if ({ram_wr, busy, done, intr, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000", {ram_wr, busy, done, intr, err});
    end
    n_tests++;
    if ({ram_addr, ram_din, word_cnt, frame_cnt} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_values: addr=%h din=%h wc=%0d fc=%0d expected all 0",
               ram_addr, ram_din, word_cnt, frame_cnt);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_oneshot();
    logic [31:0] exp_d;
    start_frame(3'd1, 2'd0, 1'b0, 16'd4);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL oneshot_busy: got %b expected 1", busy); end
    for (int i = 0; i < 4; i++) begin
      exp_d = 32'h11111111 * (i + 1);
      src_data[1*DW +: DW] = exp_d;
      src_valid = 4'b0010;
      cyc();
      n_tests++;
      if (ram_wr !== 1'b1 || ram_addr !== 32'(4 * i) || ram_din !== exp_d ||
          word_cnt !== 16'(i + 1) || done !== 1'b0) begin
        n_fail++;
        $display("FAIL oneshot_write%0d: wr=%b addr=%h din=%h wc=%0d done=%b expected 1 %h %h %0d 0",
                 i, ram_wr, ram_addr, ram_din, word_cnt, done, 4 * i, exp_d, i + 1);
      end
    end
    src_valid = '0;
    cyc();
    n_tests++;
    if (done !== 1'b1 || frame_cnt !== 16'd1 || busy !== 1'b0 || ram_wr !== 1'b0 || intr !== 1'b1) begin
      n_fail++;
      $display("FAIL oneshot_done: done=%b fc=%0d busy=%b wr=%b intr=%b expected 1 1 0 0 1",
               done, frame_cnt, busy, ram_wr, intr);
    end
    cyc();
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL oneshot_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_swap();
    logic [31:0] exp_tab [4];
    exp_tab[0] = 32'hAABBCCDD; exp_tab[1] = 32'hBBAADDCC;
    exp_tab[2] = 32'hDDCCBBAA; exp_tab[3] = 32'hCCDDAABB;
    for (int m = 0; m < 4; m++) begin
      start_frame(3'd0, 2'(m), 1'b0, 16'd1);
      src_data[0 +: DW] = 32'hAABBCCDD;
      src_valid = 4'b0001;
      cyc();
      src_valid = '0;
      n_tests++;
      if (ram_wr !== 1'b1 || ram_din !== exp_tab[m]) begin
        n_fail++;
        $display("FAIL swap_mode%0d: wr=%b din=%h expected 1 %h", m, ram_wr, ram_din, exp_tab[m]);
      end
      cyc(); cyc();
    end
  endtask

  task automatic test_ring();
    start_frame(3'd2, 2'd0, 1'b1, 16'd3);
    for (int i = 0; i < 7; i++) begin
      src_data[2*DW +: DW] = 32'(i);
      src_valid = 4'b0100;
      cyc();
      n_tests++;
      if (ram_wr !== 1'b1 || ram_addr !== 32'(4 * (i % 4)) || done !== (i == 2 || i == 5)) begin
        n_fail++;
        $display("FAIL ring_write%0d: wr=%b addr=%h done=%b expected 1 %h %b",
                 i, ram_wr, ram_addr, done, 4 * (i % 4), (i == 2 || i == 5));
      end
    end
    src_valid = '0;
    n_tests++;
    if (frame_cnt !== 16'd2 || word_cnt !== 16'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ring_counts: fc=%0d wc=%0d busy=%b expected 2 1 1", frame_cnt, word_cnt, busy);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    cyc();
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ring_stop: done=%b busy=%b expected 1 0", done, busy);
    end
  endtask

  task automatic test_stop();
    start_frame(3'd3, 2'd0, 1'b0, 16'd8);
    for (int i = 0; i < 3; i++) begin
      src_data[3*DW +: DW] = 32'hC0DE0000 + 32'(i);
      src_data[0 +: DW]    = 32'hBAD0BAD0;
      src_valid = 4'b1001;
      stop = (i == 2);
      cyc();
    end
    stop = 1'b0;
    src_valid = '0;
    n_tests++;
    if (ram_wr !== 1'b1 || ram_din !== 32'hC0DE0002 || ram_addr !== 32'd8 || word_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL stop_last_word: wr=%b din=%h addr=%h wc=%0d expected 1 c0de0002 8 3",
               ram_wr, ram_din, ram_addr, word_cnt);
    end
    cyc();
    n_tests++;
    if (done !== 1'b1 || word_cnt !== 16'd3 || frame_cnt !== 16'd1 || ram_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_done: done=%b wc=%0d fc=%0d wr=%b expected 1 3 1 0",
               done, word_cnt, frame_cnt, ram_wr);
    end
    start_frame(3'd1, 2'd0, 1'b0, 16'd2);
    for (int i = 0; i < 3; i++) begin
      src_valid = 4'b1101;
      cyc();
      n_tests++;
      if (ram_wr !== 1'b0 || word_cnt !== 16'd0) begin
        n_fail++;
        $display("FAIL unselected%0d: wr=%b wc=%0d expected 0 0", i, ram_wr, word_cnt);
      end
    end
    src_valid = '0;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    cyc();
  endtask

  task automatic test_err();
    start_frame(3'd0, 2'd0, 1'b0, 16'd0);
    n_tests++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL err_len0: err=%b busy=%b expected 1 0", err, busy);
    end
    start_frame(3'd0, 2'd0, 1'b0, 16'd1);
    n_tests++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL err_clear: err=%b busy=%b expected 0 1", err, busy);
    end
    src_valid = 4'b0001;
    cyc();
    src_valid = '0;
    cyc(); cyc();
    start_frame(3'd4, 2'd0, 1'b0, 16'd2);
    n_tests++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL err_badsel: err=%b busy=%b expected 1 0", err, busy);
    end
    stop = 1'b1;
    start_frame(3'd0, 2'd0, 1'b0, 16'd2);
    stop = 1'b0;
    n_tests++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL start_with_stop: err=%b busy=%b expected 1 0", err, busy);
    end
    start_frame(3'd0, 2'd0, 1'b0, 16'd2);
    n_tests++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL err_clear2: err=%b busy=%b expected 0 1", err, busy);
    end
  endtask

  task automatic test_reset_mid();
    // Continues the len=2 frame opened by test_err: one word, then reset.
    src_valid = 4'b0001;
    cyc();
    rst_n = 1'b0;
    cyc();
    src_valid = '0;
    n_tests++;
    if ({ram_wr, busy, done, intr, err} !== 5'b0 || word_cnt !== 16'd0 ||
        frame_cnt !== 16'd0 || ram_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid: wr/busy/done/intr/err=%b wc=%0d fc=%0d addr=%h expected 0",
               {ram_wr, busy, done, intr, err}, word_cnt, frame_cnt, ram_addr);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_intr_clr();
    start_frame(3'd0, 2'd0, 1'b0, 16'd1);
    src_valid = 4'b0001;
    cyc();
    src_valid = '0;
    intr_clr = 1'b1;
    cyc();
    intr_clr = 1'b0;
    n_tests++;
    if (done !== 1'b1 || intr !== 1'b1) begin
      n_fail++; $display("FAIL intr_set_wins: done=%b intr=%b expected 1 1", done, intr);
    end
    intr_clr = 1'b1;
    cyc();
    intr_clr = 1'b0;
    n_tests++;
    if (intr !== 1'b0) begin n_fail++; $display("FAIL intr_clear: got %b expected 0", intr); end
  endtask

  initial begin
    rst_n = 1'b0; src_data = '0; src_valid = '0; src_sel = '0; swap_mode = '0;
    ring_mode = 1'b0; frame_len = '0; start = 1'b0; stop = 1'b0; intr_clr = 1'b0;
    test_reset();
    test_oneshot();
    test_swap();
    test_ring();
    test_stop();
    test_err();
    test_reset_mid();
    test_intr_clr();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
